// File: rtl/ctrl_trans_fsm.sv
// Transaction-layer control FSM: sequences the arbiter enable and FIFO threshold
// configuration, tracks pending traffic and traps FIFO errors in a sticky state.
module ctrl_trans_fsm #(
  parameter int unsigned AW     = 3,
  parameter int unsigned DEF_AF = 6,
  parameter int unsigned DEF_AE = 1,
  parameter int unsigned CW     = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic [AW-1:0] umbral_af_in,
  input  logic [AW-1:0] umbral_ae_in,
  input  logic [7:0]    empty_vec,
  input  logic [7:0]    error_vec,
  output logic [2:0]    state,
  output logic [AW-1:0] umbral_af_out,
  output logic [AW-1:0] umbral_ae_out,
  output logic          arb_en,
  output logic          idle_out,
  output logic          error_out,
  output logic [7:0]    error_src,
  output logic [CW-1:0] err_count
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] af_q, ae_q;
  logic          arb_en_q, idle_q, error_q;
  logic [7:0]    src_q;
  logic [CW-1:0] cnt_q;
  logic          any_err, cfg_ok, load_d;

  assign any_err = |error_vec;
  assign cfg_ok  = (umbral_af_in != '0) && (umbral_ae_in < umbral_af_in);

  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT: begin
        if (any_err)     state_d = S_ERROR;
        else if (init)   state_d = S_INIT;
        else if (cfg_ok) begin
          state_d = S_IDLE;
          load_d  = 1'b1;
        end
        else             state_d = S_ERROR;
      end
      S_IDLE: begin
        if (any_err)         state_d = S_ERROR;
        else if (init)       state_d = S_INIT;
        else if (~&empty_vec) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (any_err)         state_d = S_ERROR;
        else if (init)       state_d = S_INIT;
        else if (&empty_vec) state_d = S_IDLE;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_RESET;
    endcase
  end

  // Flag outputs decode the next state so they line up with the registered state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_RESET;
      af_q     <= AW'(DEF_AF);
      ae_q     <= AW'(DEF_AE);
      arb_en_q <= 1'b0;
      idle_q   <= 1'b0;
      error_q  <= 1'b0;
      src_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      if (load_d) begin
        af_q <= umbral_af_in;
        ae_q <= umbral_ae_in;
      end
      arb_en_q <= (state_d == S_IDLE) || (state_d == S_ACTIVE);
      idle_q   <= (state_d == S_IDLE);
      error_q  <= (state_d == S_ERROR);
      if (any_err && (state_d == S_ERROR)) src_q <= src_q | error_vec;
      if (any_err && (cnt_q != '1))        cnt_q <= cnt_q + CW'(1);
    end
  end

  assign state         = state_q;
  assign umbral_af_out = af_q;
  assign umbral_ae_out = ae_q;
  assign arb_en        = arb_en_q;
  assign idle_out      = idle_q;
  assign error_out     = error_q;
  assign error_src     = src_q;
  assign err_count     = cnt_q;

endmodule

// File: tb/tb_ctrl_trans_fsm.sv
// Directed bench for ctrl_trans_fsm with hand-computed expectations.
module tb_ctrl_trans_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [2:0] umbral_af_in, umbral_ae_in;
  logic [7:0] empty_vec, error_vec;
  logic [2:0] state;
  logic [2:0] umbral_af_out, umbral_ae_out;
  logic       arb_en, idle_out, error_out;
  logic [7:0] error_src;
  logic [3:0] err_count;

  int checks = 0;
  int errors = 0;

  ctrl_trans_fsm dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_af_in(umbral_af_in), .umbral_ae_in(umbral_ae_in),
    .empty_vec(empty_vec), .error_vec(error_vec),
    .state(state), .umbral_af_out(umbral_af_out), .umbral_ae_out(umbral_ae_out),
    .arb_en(arb_en), .idle_out(idle_out), .error_out(error_out),
    .error_src(error_src), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; umbral_af_in = '0; umbral_ae_in = '0;
    empty_vec = 8'hFF; error_vec = 8'h00;
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_af", umbral_af_out, 6);
    chk("rst_ae", umbral_ae_out, 1);
    chk("rst_arb", arb_en, 0);
    chk("rst_idle", idle_out, 0);
    chk("rst_err", error_out, 0);
    chk("rst_src", error_src, 0);
    chk("rst_cnt", err_count, 0);

    // Bring-up with thresholds 5/2
    reset = 1'b0; init = 1'b1; umbral_af_in = 3'd5; umbral_ae_in = 3'd2;
    step(); chk("bring_s1", state, 1);
    step(); chk("bring_s2", state, 1);
    step(); chk("bring_s3", state, 1);
    chk("init_af_held", umbral_af_out, 6);
    chk("init_arb", arb_en, 0);
    init = 1'b0;
    step();
    chk("idle_state", state, 2);
    chk("idle_af", umbral_af_out, 5);
    chk("idle_ae", umbral_ae_out, 2);
    chk("idle_arb", arb_en, 1);
    chk("idle_flag", idle_out, 1);

    // Traffic pending for 4 cycles
    empty_vec = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("active_state", state, 3);
      chk("active_arb", arb_en, 1);
      chk("active_idle", idle_out, 0);
    end
    empty_vec = 8'hFF;
    step();
    chk("drain_state", state, 2);
    chk("drain_arb", arb_en, 1);

    // Error from ACTIVE
    empty_vec = 8'hFE;
    step(); chk("reactive", state, 3);
    error_vec = 8'h20;
    step();
    chk("err_state", state, 4);
    chk("err_flag", error_out, 1);
    chk("err_src", error_src, 8'h20);
    chk("err_cnt", err_count, 1);
    chk("err_arb", arb_en, 0);
    error_vec = 8'h00; init = 1'b1;
    step();
    chk("err_absorb", state, 4);
    chk("err_cnt_hold", err_count, 1);
    init = 1'b0;

    // Saturation of error counter, sticky source accumulation
    error_vec = 8'h01;
    for (int i = 0; i < 3; i++) step();
    chk("cnt_mid", err_count, 4);
    for (int i = 0; i < 17; i++) step();
    chk("cnt_sat", err_count, 15);
    chk("src_accum", error_src, 8'h21);
    chk("sat_state", state, 4);
    error_vec = 8'h00;

    // Invalid config: ae > af
    reset = 1'b1; #1;
    chk("rst2_cnt", err_count, 0);
    chk("rst2_src", error_src, 0);
    reset = 1'b0; init = 1'b1; umbral_af_in = 3'd2; umbral_ae_in = 3'd3;
    step(); chk("bad_s1", state, 1);
    init = 1'b0;
    step();
    chk("bad_state", state, 4);
    chk("bad_af", umbral_af_out, 6);
    chk("bad_ae", umbral_ae_out, 1);
    chk("bad_src", error_src, 0);
    chk("bad_cnt", err_count, 0);

    // Boundary: ae == af is not a valid configuration
    reset = 1'b1; #1; reset = 1'b0;
    init = 1'b1; umbral_af_in = 3'd3; umbral_ae_in = 3'd3;
    step(); init = 1'b0;
    step(); chk("eq_state", state, 4);

    // Boundary: af == 0 invalid
    reset = 1'b1; #1; reset = 1'b0;
    init = 1'b1; umbral_af_in = 3'd0; umbral_ae_in = 3'd0;
    step(); init = 1'b0;
    step(); chk("af0_state", state, 4);

    // Init vs traffic in IDLE, then async reset in ACTIVE
    reset = 1'b1; #1; reset = 1'b0;
    init = 1'b1; umbral_af_in = 3'd7; umbral_ae_in = 3'd0;
    step(); init = 1'b0;
    step(); chk("idle2", state, 2);
    chk("idle2_af", umbral_af_out, 7);
    init = 1'b1; empty_vec = 8'h7F;
    step();
    chk("init_wins", state, 1);
    chk("init_wins_arb", arb_en, 0);
    chk("init_af_kept", umbral_af_out, 7);
    init = 1'b0; umbral_af_in = 3'd4; umbral_ae_in = 3'd1;
    step(); chk("reload_idle", state, 2);
    chk("reload_af", umbral_af_out, 4);
    step(); chk("act2", state, 3);
    #2 reset = 1'b1;
    #1;
    chk("async_state", state, 0);
    chk("async_arb", arb_en, 0);
    chk("async_af", umbral_af_out, 6);
    chk("async_ae", umbral_ae_out, 1);
    chk("async_idle", idle_out, 0);
    #1 reset = 1'b0;
    chk("post_rst_state", state, 0);
    empty_vec = 8'hFF;
    step(); chk("post_rst_init", state, 1);

    // Error and init together in INIT
    init = 1'b1; error_vec = 8'h02;
    step();
    chk("errinit_state", state, 4);
    chk("errinit_src", error_src, 8'h02);
    chk("errinit_cnt", err_count, 1);
    init = 1'b0; error_vec = 8'h00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
